decode_stage: RTL and testbench

- Registered, parametrised RV32I/RV64I-style instruction decode stage between fetch and execute.
- Splits each instruction into opcode, rd, funct3, rs1, rs2 and funct7, and sign-extends the immediate to XLEN.
- Classifies the immediate format and flags illegal encodings.
- Valid/ready handshakes on both sides, with a 2-entry skid buffer for full throughput, plus a pipeline flush.

---
 rtl/decode_stage.sv | 229 ++++++++++++++++++++++
 tb/tb_decode_stage.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// RV32I/RV64I decode stage: field split, immediate sign-extension, illegal detection,
// valid/ready with a 2-entry skid. Optional DECODE_PERF_EN adds transfer counters.
module decode_stage #(
  parameter int XLEN = 32,
  parameter int PC_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [6:0]      opcode,
  output logic [4:0]      rd,
  output logic [2:0]      funct3,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [6:0]      funct7,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      imm_type,
  output logic            illegal
`ifdef DECODE_PERF_EN
  ,
  output logic [31:0]     perf_decoded,
  output logic [31:0]     perf_illegal
`endif
);

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [2:0] IMM_I    = 3'b000;
  localparam logic [2:0] IMM_S    = 3'b001;
  localparam logic [2:0] IMM_B    = 3'b010;
  localparam logic [2:0] IMM_U    = 3'b011;
  localparam logic [2:0] IMM_J    = 3'b100;
  localparam logic [2:0] IMM_NONE = 3'b111;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [2:0]      funct3;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm;
    logic [2:0]      imm_type;
    logic            illegal;
  } dec_t;

  state_t      state, state_n;
  dec_t        dec, out_q, skid_q;
  logic [31:0] imm32;
  logic [2:0]  fmt;
  logic        bad;
  logic        accept, fire, load_out, load_skid, skid_to_out;

  // Immediates are built as 32-bit sign-extended patterns, then widened to XLEN.
  always_comb begin
    imm32 = '0;
    fmt   = IMM_NONE;
    bad   = 1'b0;
    case (in_instr[6:0])
      OPC_OP_IMM: begin
        imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
        fmt   = IMM_I;
        if (in_instr[14:12] == 3'b001)
          bad = (in_instr[31:26] != 6'b000000) || (XLEN == 32 && in_instr[25]);
        else if (in_instr[14:12] == 3'b101)
          bad = (in_instr[31:26] != 6'b000000 && in_instr[31:26] != 6'b010000) ||
                (XLEN == 32 && in_instr[25]);
      end
      OPC_LOAD: begin
        imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
        fmt   = IMM_I;
        bad   = (in_instr[14:12] == 3'b111) ||
                (XLEN == 32 && (in_instr[14:12] == 3'b011 || in_instr[14:12] == 3'b110));
      end
      OPC_JALR: begin
        imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
        fmt   = IMM_I;
        bad   = (in_instr[14:12] != 3'b000);
      end
      OPC_FENCE, OPC_SYSTEM: begin
        imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
        fmt   = IMM_I;
      end
      OPC_STORE: begin
        imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
        fmt   = IMM_S;
        bad   = (in_instr[14:12] > ((XLEN == 64) ? 3'd3 : 3'd2));
      end
      OPC_BRANCH: begin
        imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                 in_instr[11:8], 1'b0};
        fmt   = IMM_B;
        bad   = (in_instr[14:12] == 3'b010) || (in_instr[14:12] == 3'b011);
      end
      OPC_LUI, OPC_AUIPC: begin
        imm32 = {in_instr[31:12], 12'b0};
        fmt   = IMM_U;
      end
      OPC_JAL: begin
        imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                 in_instr[30:21], 1'b0};
        fmt   = IMM_J;
      end
      OPC_OP: begin
        bad = (in_instr[31:25] != 7'b0000000) && (in_instr[31:25] != 7'b0100000);
      end
      default: bad = 1'b1;
    endcase
    if (in_instr[1:0] != 2'b11)
      bad = 1'b1;
    if (bad) begin
      imm32 = '0;
      fmt   = IMM_NONE;
    end

    dec          = '0;
    dec.pc       = in_pc;
    dec.opcode   = in_instr[6:0];
    dec.rd       = in_instr[11:7];
    dec.funct3   = in_instr[14:12];
    dec.rs1      = in_instr[19:15];
    dec.rs2      = in_instr[24:20];
    dec.funct7   = in_instr[31:25];
    dec.imm      = XLEN'($signed(imm32));
    dec.imm_type = fmt;
    dec.illegal  = bad;
  end

  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign accept    = in_valid && in_ready && !flush;
  assign fire      = out_valid && out_ready;

  // Flush overrides everything; in FULL no accept is possible since in_ready is low.
  always_comb begin
    state_n     = state;
    load_out    = 1'b0;
    load_skid   = 1'b0;
    skid_to_out = 1'b0;
    if (flush) begin
      state_n = EMPTY;
    end else begin
      case (state)
        EMPTY: if (accept) begin
          load_out = 1'b1;
          state_n  = ONE;
        end
        ONE: begin
          if (accept && out_ready) begin
            load_out = 1'b1;
          end else if (accept) begin
            load_skid = 1'b1;
            state_n   = FULL;
          end else if (out_ready) begin
            state_n = EMPTY;
          end
        end
        FULL: if (out_ready) begin
          skid_to_out = 1'b1;
          state_n     = ONE;
        end
        default: state_n = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= EMPTY;
    else     state <= state_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q           <= '0;
      out_q.imm_type  <= IMM_NONE;
      skid_q          <= '0;
      skid_q.imm_type <= IMM_NONE;
    end else begin
      if (load_out)         out_q <= dec;
      else if (skid_to_out) out_q <= skid_q;
      if (load_skid)        skid_q <= dec;
    end
  end

  assign out_pc   = out_q.pc;
  assign opcode   = out_q.opcode;
  assign rd       = out_q.rd;
  assign funct3   = out_q.funct3;
  assign rs1      = out_q.rs1;
  assign rs2      = out_q.rs2;
  assign funct7   = out_q.funct7;
  assign imm      = out_q.imm;
  assign imm_type = out_q.imm_type;
  assign illegal  = out_q.illegal;

`ifdef DECODE_PERF_EN
  // Counters follow output transfers only, so flushed instructions are never counted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_decoded <= '0;
      perf_illegal <= '0;
    end else if (fire) begin
      perf_decoded <= perf_decoded + 32'd1;
      if (out_q.illegal) perf_illegal <= perf_illegal + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: directed vectors queued on accept, checked on transfer.
module tb_decode_stage;
  localparam int XLEN = 32;
  localparam int PC_W = 32;
  localparam int OW   = PC_W + 32 + XLEN + 4;

  logic            clk = 1'b0;
  logic            rst, flush, in_valid, out_ready;
  logic [31:0]     in_instr;
  logic [PC_W-1:0] in_pc;
  logic            in_ready, out_valid, illegal;
  logic [PC_W-1:0] out_pc;
  logic [6:0]      opcode, funct7;
  logic [4:0]      rd, rs1, rs2;
  logic [2:0]      funct3, imm_type;
  logic [XLEN-1:0] imm;
`ifdef DECODE_PERF_EN
  logic [31:0]     perf_decoded, perf_illegal;
  logic [31:0]     perf_ill_start;
`endif

  typedef struct {
    logic [31:0]     instr;
    logic [PC_W-1:0] pc;
    logic [63:0]     imm;
    logic [2:0]      imm_type;
    logic            illegal;
  } exp_t;

  exp_t          sb[$];
  int            errors = 0;
  int            checks = 0;
  int            xfers = 0;
  int            ill_xfers = 0;
  logic          held = 1'b0;
  logic [OW-1:0] snap;
  logic [OW-1:0] cur;

  decode_stage #(.XLEN(XLEN), .PC_W(PC_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .opcode(opcode), .rd(rd), .funct3(funct3), .rs1(rs1), .rs2(rs2), .funct7(funct7),
    .imm(imm), .imm_type(imm_type), .illegal(illegal)
`ifdef DECODE_PERF_EN
    , .perf_decoded(perf_decoded), .perf_illegal(perf_illegal)
`endif
  );

  always #5 clk = ~clk;

  assign cur = {out_pc, opcode, rd, funct3, rs1, rs2, funct7, imm, imm_type, illegal};

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
    end
  endtask

  // Monitor: output stability while stalled, and in-order scoreboard on every transfer.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      held = 1'b0;
    end else begin
      if (held && out_valid) begin
        checks++;
        if (cur !== snap) begin
          errors++;
          $display("[TB] FAIL hold: got 0x%0h, want 0x%0h", cur, snap);
        end
      end
      held = out_valid && !out_ready;
      snap = cur;
      if (out_valid && out_ready) begin
        xfers++;
        if (illegal) ill_xfers++;
        if (sb.size() == 0) begin
          checkOutput("stale_xfer_pc", 64'(out_pc), 64'hDEAD);
        end else begin
          e = sb.pop_front();
          checkOutput("xfer_pc", 64'(out_pc), 64'(e.pc));
          checkOutput("xfer_fields", {32'd0, funct7, rs2, rs1, funct3, rd, opcode},
                      {32'd0, e.instr});
          checkOutput("xfer_imm", 64'(imm), 64'(e.imm[XLEN-1:0]));
          checkOutput("xfer_type_ill", {60'd0, imm_type, illegal}, {60'd0, e.imm_type, e.illegal});
        end
      end
    end
  end

  task automatic applyStimulus(input logic [31:0] instr, input logic [PC_W-1:0] pc,
                               input logic [63:0] exp_imm, input logic [2:0] exp_type,
                               input logic exp_ill);
    exp_t e;
    in_valid = 1'b1;
    in_instr = instr;
    in_pc    = pc;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        e.instr = instr; e.pc = pc; e.imm = exp_imm; e.imm_type = exp_type; e.illegal = exp_ill;
        sb.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        return;
      end
    end
    checkOutput("accept_timeout", 64'(pc), 64'hFFFF);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(posedge clk);
    #1;
    checkOutput("drain_left", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b0;
    #12;
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
    checkOutput("rst_out_pc", 64'(out_pc), 64'd0);
    checkOutput("rst_fields", {32'd0, funct7, rs2, rs1, funct3, rd, opcode}, 64'd0);
    checkOutput("rst_imm", 64'(imm), 64'd0);
    checkOutput("rst_imm_type", 64'(imm_type), 64'd7);
    checkOutput("rst_illegal", 64'(illegal), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;

    applyStimulus(32'h00500093, 32'h100, 64'd5, 3'b000, 1'b0);
    @(negedge clk);
    checkOutput("addi_valid", 64'(out_valid), 64'd1);
    checkOutput("addi_rd", 64'(rd), 64'd1);
    @(posedge clk); #1;
    applyStimulus(32'hFE000EE3, 32'h104, 64'hFFFFFFFFFFFFFFFC, 3'b010, 1'b0);
    applyStimulus(32'h800002B7, 32'h108, 64'hFFFFFFFF80000000, 3'b011, 1'b0);
    applyStimulus(32'h00512423, 32'h10C, 64'd8, 3'b001, 1'b0);
    applyStimulus(32'h001000EF, 32'h110, 64'h800, 3'b100, 1'b0);
    applyStimulus(32'hFFF00093, 32'h114, 64'hFFFFFFFFFFFFFFFF, 3'b000, 1'b0);
    applyStimulus(32'h002081B3, 32'h118, 64'd0, 3'b111, 1'b0);
    applyStimulus(32'h402081B3, 32'h11C, 64'd0, 3'b111, 1'b0);
    applyStimulus(32'h022081B3, 32'h120, 64'd0, 3'b111, 1'b1);
    applyStimulus(32'h00002063, 32'h124, 64'd0, 3'b111, 1'b1);
    applyStimulus(32'h02009093, 32'h128, (XLEN == 32) ? 64'd0 : 64'd32,
                  (XLEN == 32) ? 3'b111 : 3'b000, XLEN == 32);
    drain();

    // Back-pressure: two accepts fill the stage, the third waits for out_ready.
    out_ready = 1'b0;
    applyStimulus(32'h00A00113, 32'h200, 64'd10, 3'b000, 1'b0);
    applyStimulus(32'h00B00193, 32'h204, 64'd11, 3'b000, 1'b0);
    checkOutput("full_in_ready", 64'(in_ready), 64'd0);
    checkOutput("full_hold_pc", 64'(out_pc), 64'h200);
    fork
      applyStimulus(32'h00C00213, 32'h208, 64'd12, 3'b000, 1'b0);
      begin
        repeat (2) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // Flush from FULL with a new instruction offered in the same cycle.
    out_ready = 1'b0;
    applyStimulus(32'h00100293, 32'h300, 64'd1, 3'b000, 1'b0);
    applyStimulus(32'h00200313, 32'h304, 64'd2, 3'b000, 1'b0);
    in_valid = 1'b1; in_instr = 32'h00300393; in_pc = 32'h308; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    sb.delete();
    checkOutput("flush_full_valid", 64'(out_valid), 64'd0);
    checkOutput("flush_full_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    repeat (5) @(posedge clk); #1;
    checkOutput("flush_full_quiet", 64'(out_valid), 64'd0);

    // Flush from ONE: the offered instruction must be dropped, not accepted.
    out_ready = 1'b0;
    applyStimulus(32'h00400413, 32'h400, 64'd4, 3'b000, 1'b0);
    in_valid = 1'b1; in_instr = 32'h00500493; in_pc = 32'h404; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    sb.delete();
    checkOutput("flush_one_valid", 64'(out_valid), 64'd0);
    out_ready = 1'b1;
    repeat (4) @(posedge clk); #1;
    checkOutput("flush_one_quiet", 64'(out_valid), 64'd0);

`ifdef DECODE_PERF_EN
    perf_ill_start = perf_illegal;
`endif
    applyStimulus(32'h00000000, 32'h500, 64'd0, 3'b111, 1'b1);
    applyStimulus(32'h00003003, 32'h504, 64'd0, (XLEN == 32) ? 3'b111 : 3'b000, XLEN == 32);
    drain();
`ifdef DECODE_PERF_EN
    checkOutput("perf_ill_delta", 64'(perf_illegal - perf_ill_start), (XLEN == 32) ? 64'd2 : 64'd1);
    checkOutput("perf_decoded", 64'(perf_decoded), 64'(xfers));
    checkOutput("perf_illegal", 64'(perf_illegal), 64'(ill_xfers));
`endif

    // Asynchronous reset in the middle of a cycle while FULL.
    out_ready = 1'b0;
    applyStimulus(32'h00600513, 32'h600, 64'd6, 3'b000, 1'b0);
    applyStimulus(32'h00700593, 32'h604, 64'd7, 3'b000, 1'b0);
    #2 rst = 1'b1;
    #1;
    checkOutput("mid_rst_valid", 64'(out_valid), 64'd0);
    checkOutput("mid_rst_ready", 64'(in_ready), 64'd1);
    checkOutput("mid_rst_pc", 64'(out_pc), 64'd0);
    checkOutput("mid_rst_type", 64'(imm_type), 64'd7);
`ifdef DECODE_PERF_EN
    checkOutput("mid_rst_perf", 64'(perf_decoded), 64'd0);
`endif
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk); #1;
    checkOutput("post_rst_valid", 64'(out_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
